// File: rtl/instruction_fetch_ctrl.sv
// PC sequencer for a combinational instruction memory with a one-entry registered valid/ready output.
// Define IFETCH_PERF_COUNT_EN to add a transfer counter on fetch_count; otherwise fetch_count is tied to 0.
module instruction_fetch_ctrl #(
   parameter int NUM_INSTRUCTIONS = 2,
   parameter int RESET_PC         = 0
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        start,
   output logic [31:0] program_counter,
   input  logic [31:0] instruction,
   output logic [31:0] fetch_instruction,
   output logic [31:0] fetch_pc,
   output logic        fetch_valid,
   input  logic        fetch_ready,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        busy,
   output logic        done,
   output logic [31:0] fetch_count
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_FETCH = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_HALT  = 2'd3;

   localparam logic [31:0] NUM_PC  = 32'(NUM_INSTRUCTIONS);
   localparam logic [31:0] LAST_PC = 32'(NUM_INSTRUCTIONS - 1);
   localparam logic [31:0] RST_PC  = 32'(RESET_PC);

   logic [1:0]  state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] fpc_q, fpc_d;
   logic        valid_q, valid_d;
   logic        transfer;
   logic        start_accept;

   assign transfer     = valid_q & fetch_ready;
   assign start_accept = start & ((state_q == S_IDLE) | (state_q == S_HALT));

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      fpc_d   = fpc_q;
      valid_d = valid_q;
      case (state_q)
         S_IDLE, S_HALT: begin
            if (start) begin
               state_d = S_FETCH;
               pc_d    = RST_PC;
               valid_d = 1'b0;
            end
         end
         S_FETCH, S_DRAIN: begin
            // A redirect wins over capture; an out-of-range target stops the fetcher with pc untouched.
            if (redirect_valid) begin
               valid_d = 1'b0;
               if (redirect_pc >= NUM_PC) begin
                  state_d = S_HALT;
               end else begin
                  pc_d    = redirect_pc;
                  state_d = S_FETCH;
               end
            end else if (state_q == S_FETCH) begin
               if (!valid_q || transfer) begin
                  instr_d = instruction;
                  fpc_d   = pc_q;
                  valid_d = 1'b1;
                  if (pc_q >= LAST_PC) begin
                     state_d = S_DRAIN;
                  end else begin
                     pc_d = pc_q + 32'd1;
                  end
               end
            end else if (transfer) begin
               valid_d = 1'b0;
               state_d = S_HALT;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         pc_q    <= RST_PC;
         instr_q <= '0;
         fpc_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         fpc_q   <= fpc_d;
         valid_q <= valid_d;
      end
   end

`ifdef IFETCH_PERF_COUNT_EN
   logic [31:0] count_q;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         count_q <= '0;
      end else if (start_accept) begin
         count_q <= '0;
      end else if (transfer) begin
         count_q <= count_q + 32'd1;
      end
   end

   assign fetch_count = count_q;
`else
   logic unused_start_accept;
   assign unused_start_accept = start_accept;
   assign fetch_count         = '0;
`endif

   assign program_counter   = pc_q;
   assign fetch_instruction = instr_q;
   assign fetch_pc          = fpc_q;
   assign fetch_valid       = valid_q;
   assign busy              = (state_q == S_FETCH) | (state_q == S_DRAIN);
   assign done              = (state_q == S_HALT);

endmodule

// File: tb/tb_instruction_fetch_ctrl.sv
// Randomized bench for instruction_fetch_ctrl against a flag-level reference model of the fetcher.
module tb_instruction_fetch_ctrl;

   localparam int N     = 8;
   localparam int RST_PC = 0;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        start;
   logic [31:0] program_counter;
   logic [31:0] instruction;
   logic [31:0] fetch_instruction;
   logic [31:0] fetch_pc;
   logic        fetch_valid;
   logic        fetch_ready;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        busy;
   logic        done;
   logic [31:0] fetch_count;

   logic [31:0] mem [N];

   int errors = 0;
   int checks = 0;
   int cycle  = 0;

   // reference model: running / reached-last-word / halted flags plus the output slot
   bit          m_run, m_end, m_halt, m_valid;
   logic [31:0] m_pc, m_ipc, m_instr, m_cnt;

   always #5 clock = ~clock;

   assign instruction = (program_counter < 32'(N)) ? mem[program_counter[2:0]] : 32'hDEAD_BEEF;

   instruction_fetch_ctrl #(
      .NUM_INSTRUCTIONS(N),
      .RESET_PC        (RST_PC)
   ) dut (
      .clock            (clock),
      .reset_n          (reset_n),
      .start            (start),
      .program_counter  (program_counter),
      .instruction      (instruction),
      .fetch_instruction(fetch_instruction),
      .fetch_pc         (fetch_pc),
      .fetch_valid      (fetch_valid),
      .fetch_ready      (fetch_ready),
      .redirect_valid   (redirect_valid),
      .redirect_pc      (redirect_pc),
      .busy             (busy),
      .done             (done),
      .fetch_count      (fetch_count)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s cycle=%0d got=%h exp=%h", tag, cycle, got, exp);
      end
   endtask

   function automatic logic [31:0] exp_count();
`ifdef IFETCH_PERF_COUNT_EN
      return m_cnt;
`else
      return 32'd0;
`endif
   endfunction

   task automatic model_reset();
      m_run = 0; m_end = 0; m_halt = 0; m_valid = 0;
      m_pc = 32'(RST_PC); m_ipc = '0; m_instr = '0; m_cnt = '0;
   endtask

   task automatic model_step(input bit s, input bit r, input bit rv, input logic [31:0] rpc);
      bit xfer;
      xfer = m_valid && r;
      if (xfer) m_cnt = m_cnt + 32'd1;
      if (!m_run) begin
         if (s) begin
            m_run = 1; m_end = 0; m_halt = 0; m_valid = 0;
            m_pc = 32'(RST_PC); m_cnt = '0;
         end
      end else if (rv) begin
         m_valid = 0;
         if (rpc >= 32'(N)) begin
            m_run = 0; m_halt = 1;
         end else begin
            m_pc = rpc; m_end = 0;
         end
      end else if (!m_end) begin
         if (!m_valid || xfer) begin
            m_instr = mem[m_pc[2:0]];
            m_ipc   = m_pc;
            m_valid = 1;
            if (m_pc == 32'(N - 1)) m_end = 1;
            else m_pc = m_pc + 32'd1;
         end
      end else if (xfer) begin
         m_valid = 0; m_run = 0; m_halt = 1;
      end
   endtask

   task automatic compare_all();
      check_eq("program_counter", program_counter, m_pc);
      check_eq("fetch_valid", 32'(fetch_valid), 32'(m_valid));
      check_eq("fetch_pc", fetch_pc, m_ipc);
      check_eq("fetch_instruction", fetch_instruction, m_instr);
      check_eq("busy", 32'(busy), 32'(m_run));
      check_eq("done", 32'(done), 32'(m_halt));
      check_eq("fetch_count", fetch_count, exp_count());
   endtask

   // called at a falling edge: drive, advance the model, observe after the next rising edge
   task automatic step(input bit s, input bit r, input bit rv, input logic [31:0] rpc);
      start          = s;
      fetch_ready    = r;
      redirect_valid = rv;
      redirect_pc    = rpc;
      model_step(s, r, rv, rpc);
      @(negedge clock);
      cycle++;
      compare_all();
   endtask

   task automatic async_rst();
      #2;
      reset_n = 1'b0;
      #1;
      model_reset();
      compare_all();
      start          = 1'b0;
      redirect_valid = 1'b0;
      @(negedge clock);
      cycle++;
      compare_all();
      reset_n = 1'b1;
   endtask

   initial begin
      reset_n        = 1'b0;
      start          = 1'b0;
      fetch_ready    = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      mem[0] = 32'h2008_0005;
      mem[1] = 32'h2109_0003;
      for (int i = 2; i < N; i++) mem[i] = $urandom;
      model_reset();

      repeat (2) @(negedge clock);
      compare_all();
      reset_n = 1'b1;

      // stall after first capture, then redirect, then out-of-range redirect
      step(1, 1, 0, 0);
      check_eq("busy_after_start", 32'(busy), 32'd1);
      step(0, 1, 0, 0);
      for (int i = 0; i < 4; i++) begin
         step(0, 0, 0, 0);
         check_eq("stall_instr", fetch_instruction, 32'h2008_0005);
         check_eq("stall_fetch_pc", fetch_pc, 32'd0);
         check_eq("stall_pc", program_counter, 32'd1);
      end
      step(0, 1, 0, 0);
      check_eq("second_fetch_pc", fetch_pc, 32'd1);
      step(0, 0, 1, 32'd5);
      check_eq("redirect_valid_drop", 32'(fetch_valid), 32'd0);
      check_eq("redirect_pc", program_counter, 32'd5);
      step(0, 1, 0, 0);
      check_eq("post_redirect_fetch_pc", fetch_pc, 32'd5);
      step(0, 0, 1, 32'd9);
      check_eq("oob_done", 32'(done), 32'd1);
      check_eq("oob_valid", 32'(fetch_valid), 32'd0);
      check_eq("oob_pc", program_counter, 32'd6);

      // full program with ready held high
      step(1, 1, 0, 0);
      for (int i = 0; i < 9; i++) step(0, 1, 0, 0);
      check_eq("run_done", 32'(done), 32'd1);
`ifdef IFETCH_PERF_COUNT_EN
      check_eq("run_count", fetch_count, 32'd8);
`else
      check_eq("run_count", fetch_count, 32'd0);
`endif

      // reset in the middle of fetching, then restart
      step(1, 1, 0, 0);
      step(0, 1, 0, 0);
      step(0, 1, 0, 0);
      async_rst();
      step(1, 0, 0, 0);
      check_eq("restart_pc", program_counter, 32'(RST_PC));

      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 399) == 0) begin
            async_rst();
         end else begin
            step($urandom_range(0, 7) == 0,
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 15) == 0,
                 32'($urandom_range(0, 9)));
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
